mx4_rr_arbiter: RTL



---
 rtl/mx4_rr_arbiter_pkg.sv | 40 ++++
 rtl/mx2.sv | 11 +
 rtl/mx4.sv | 35 +++
 rtl/mx4_rr_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mx4_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin 4:1 mux arbiter.
// Holds the state encoding, the requester count and the circular priority scan.
package mx4_rr_arbiter_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Scan req circularly from ptr+1; walking the offsets high-to-low lets the nearest win.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [SEL_W-1:0] ptr);
        pick_t            p;
        logic [SEL_W-1:0] cand;
        p = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mx2.sv
// 1-bit 2:1 multiplexer, the leaf cell of the shared datapath.
module mx2 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_s,
    output logic o_y
);

    assign o_y = i_s ? i_b : i_a;

endmodule

// File: rtl/mx4.sv
// 1-bit 4:1 multiplexer built as a two-level tree of mx2 cells.
module mx4 (
    input  logic       i_d0,
    input  logic       i_d1,
    input  logic       i_d2,
    input  logic       i_d3,
    input  logic [1:0] i_s,
    output logic       o_y
);

    logic w_lo;
    logic w_hi;

    mx2 u_mx2_lo (
        .i_a (i_d0),
        .i_b (i_d1),
        .i_s (i_s[0]),
        .o_y (w_lo)
    );

    mx2 u_mx2_hi (
        .i_a (i_d2),
        .i_b (i_d3),
        .i_s (i_s[0]),
        .o_y (w_hi)
    );

    mx2 u_mx2_out (
        .i_a (w_lo),
        .i_b (w_hi),
        .i_s (i_s[1]),
        .o_y (o_y)
    );

endmodule

// File: rtl/mx4_rr_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit 4:1 mux among four requesters.
// Grants are quantum-limited to MAX_HOLD cycles while others wait; y/valid are registered.
module mx4_rr_arbiter
    import mx4_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] y,
    output logic             valid
);

    localparam int unsigned       HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    state_t            r_state;
    state_t            w_state_d;
    logic [SEL_W-1:0]  r_ptr;
    logic [SEL_W-1:0]  w_ptr_d;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_d;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   w_gnt_d;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  w_sel_d;
    logic [WIDTH-1:0]  r_y;
    logic [WIDTH-1:0]  w_y_d;
    logic              r_valid;
    logic              w_valid_d;

    logic [WIDTH-1:0]  w_mux_y;
    logic              w_own_req;
    logic              w_others;
    logic              w_release;
    logic              w_expire;
    logic              w_rescan;
    pick_t             w_pick_ptr;
    pick_t             w_pick_own;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        mx4 u_mx4 (
            .i_d0 (d0[b]),
            .i_d1 (d1[b]),
            .i_d2 (d2[b]),
            .i_d3 (d3[b]),
            .i_s  (r_sel),
            .o_y  (w_mux_y[b])
        );
    end

    assign w_own_req  = req[r_sel];
    assign w_others   = |(req & ~onehot(r_sel));
    assign w_release  = (r_state == GRANT) && !w_own_req;
    assign w_expire   = (r_state == GRANT) && w_own_req && (r_hold == HOLD_MAX) && w_others;
    assign w_rescan   = w_release || w_expire;
    assign w_pick_ptr = rr_pick(req, r_ptr);
    // Rescans start after the current owner, so an expiring owner cannot re-win.
    assign w_pick_own = rr_pick(req, r_sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= SEL_W'(NREQ - 1);
            r_hold  <= '0;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
            r_hold  <= w_hold_d;
            r_gnt   <= w_gnt_d;
            r_sel   <= w_sel_d;
            r_y     <= w_y_d;
            r_valid <= w_valid_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        w_hold_d  = r_hold;
        unique case (r_state)
            IDLE: begin
                if (w_pick_ptr.found) begin
                    w_state_d = GRANT;
                    w_hold_d  = HOLD_ONE;
                end
            end
            GRANT: begin
                if (w_rescan) begin
                    w_ptr_d = r_sel;
                    if (w_pick_own.found) begin
                        w_hold_d = HOLD_ONE;
                    end else begin
                        w_state_d = IDLE;
                        w_hold_d  = '0;
                    end
                end else if (r_hold == HOLD_MAX) begin
                    w_hold_d = HOLD_ONE;
                end else begin
                    w_hold_d = r_hold + HOLD_ONE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        w_gnt_d   = r_gnt;
        w_sel_d   = r_sel;
        w_y_d     = r_y;
        w_valid_d = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pick_ptr.found) begin
                    w_sel_d = w_pick_ptr.idx;
                    w_gnt_d = onehot(w_pick_ptr.idx);
                end else begin
                    w_gnt_d = '0;
                end
            end
            GRANT: begin
                if (w_own_req) begin
                    w_y_d     = w_mux_y;
                    w_valid_d = 1'b1;
                end
                if (w_rescan) begin
                    if (w_pick_own.found) begin
                        w_sel_d = w_pick_own.idx;
                        w_gnt_d = onehot(w_pick_own.idx);
                    end else begin
                        w_gnt_d = '0;
                    end
                end
            end
            default: begin
                w_gnt_d = '0;
            end
        endcase
    end

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign y     = r_y;
    assign valid = r_valid;

endmodule
